ball_motion: RTL and testbench

//  Per-ball kinematics register; the consumer end of the collision-response interface.

---
 rtl/ball_motion_pkg.sv | 19 +
 rtl/ball_axis.sv | 42 ++++
 rtl/ball_motion.sv | 148 ++++++++++++++
 tb/tb_ball_motion.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_motion_pkg.sv
// Table geometry, speed limit and FSM encoding shared by the ball kinematics
// and the collision detector.
package ball_motion_pkg;

  localparam int BALL_R  = 12;
  localparam int BALL_D  = 2 * BALL_R;
  localparam int TABLE_L = 20;
  localparam int TABLE_R = 620;
  localparam int TABLE_T = 20;
  localparam int TABLE_B = 460;
  localparam int V_MAX   = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_HOLD = 2'd2
  } ball_state_t;

endpackage

// File: rtl/ball_axis.sv
// One-axis frame step: advance position by d*v, clamp to the cushion and
// reflect the direction when the ball would cross it.
module ball_axis #(
  parameter int DATA_W = 10,
  parameter int LO     = 32,
  parameter int HI     = 608
) (
  input  logic        [DATA_W-1:0] pos,
  input  logic        [DATA_W-1:0] v,
  input  logic signed [DATA_W-1:0] d,
  output logic        [DATA_W-1:0] pos_next,
  output logic signed [DATA_W-1:0] d_next,
  output logic                     hit
);

  localparam logic signed [DATA_W:0] LO_S = (DATA_W+1)'(LO);
  localparam logic signed [DATA_W:0] HI_S = (DATA_W+1)'(HI);

  logic signed [DATA_W:0] pos_s;
  logic signed [DATA_W:0] v_s;
  logic signed [DATA_W:0] nxt;

  always_comb begin
    pos_s    = $signed({1'b0, pos});
    v_s      = $signed({1'b0, v});
    nxt      = d[DATA_W-1] ? (pos_s - v_s) : (pos_s + v_s);
    pos_next = nxt[DATA_W-1:0];
    d_next   = d;
    hit      = 1'b0;
    // One extra bit keeps a step past the low cushion negative instead of wrapping.
    if (nxt < LO_S) begin
      pos_next = DATA_W'(LO);
      d_next   = DATA_W'(1);
      hit      = 1'b1;
    end else if (nxt > HI_S) begin
      pos_next = DATA_W'(HI);
      d_next   = '1;
      hit      = 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Per-ball kinematics register: position/speed/direction state, cue shots,
// collision-result capture with cooldown, cushion reflection and friction.
module ball_motion
  import ball_motion_pkg::*;
#(
  parameter int DATA_W       = 10,
  parameter int X_INIT       = 100,
  parameter int Y_INIT       = 240,
  parameter int FRICTION_DIV = 60,
  parameter int COOLDOWN     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     shot_valid,
  input  logic        [DATA_W-1:0] shot_vx,
  input  logic        [DATA_W-1:0] shot_vy,
  input  logic        [DATA_W-1:0] shot_dx,
  input  logic        [DATA_W-1:0] shot_dy,
  input  logic                     col_valid,
  input  logic        [DATA_W-1:0] col_vx,
  input  logic        [DATA_W-1:0] col_vy,
  input  logic        [DATA_W-1:0] col_dx,
  input  logic        [DATA_W-1:0] col_dy,
  output logic                     col_ack,
  output logic        [DATA_W-1:0] x,
  output logic        [DATA_W-1:0] y,
  output logic        [DATA_W-1:0] vx,
  output logic        [DATA_W-1:0] vy,
  output logic signed [DATA_W-1:0] dx,
  output logic signed [DATA_W-1:0] dy,
  output logic                     moving,
  output logic                     wall_hit
);

  localparam int FC_W = (FRICTION_DIV > 1) ? $clog2(FRICTION_DIV) : 1;
  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [DATA_W-1:0] DIR_POS = DATA_W'(1);

  function automatic logic [DATA_W-1:0] sat_speed(input logic [DATA_W-1:0] v);
    return (v > DATA_W'(V_MAX)) ? DATA_W'(V_MAX) : v;
  endfunction

  // Only the sign of a direction input matters; zero keeps the current direction.
  function automatic logic signed [DATA_W-1:0] dir_decode(
    input logic        [DATA_W-1:0] raw,
    input logic signed [DATA_W-1:0] cur
  );
    if (raw[DATA_W-1]) return '1;
    else if (raw != '0) return DIR_POS;
    else return cur;
  endfunction

  ball_state_t state;
  logic [CD_W-1:0] cool;
  logic [FC_W-1:0] fcnt;

  logic        [DATA_W-1:0] ax_pos, ay_pos;
  logic signed [DATA_W-1:0] ax_d, ay_d;
  logic                     ax_hit, ay_hit;

  logic              capture, step_en, fr_wrap;
  logic [DATA_W-1:0] vx_fr, vy_fr, shot_vxs, shot_vys;

  ball_axis #(.DATA_W(DATA_W), .LO(TABLE_L + BALL_R), .HI(TABLE_R - BALL_R)) u_axis_x (
    .pos(x), .v(vx), .d(dx), .pos_next(ax_pos), .d_next(ax_d), .hit(ax_hit)
  );

  ball_axis #(.DATA_W(DATA_W), .LO(TABLE_T + BALL_R), .HI(TABLE_B - BALL_R)) u_axis_y (
    .pos(y), .v(vy), .d(dy), .pos_next(ay_pos), .d_next(ay_d), .hit(ay_hit)
  );

  always_comb begin
    capture  = col_valid && (state != ST_HOLD);
    step_en  = frame_tick && !capture && (state == ST_MOVE || state == ST_HOLD);
    fr_wrap  = (fcnt == FC_W'(FRICTION_DIV - 1));
    vx_fr    = (fr_wrap && vx != '0) ? vx - DATA_W'(1) : vx;
    vy_fr    = (fr_wrap && vy != '0) ? vy - DATA_W'(1) : vy;
    shot_vxs = sat_speed(shot_vx);
    shot_vys = sat_speed(shot_vy);
  end

  assign moving = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      x        <= DATA_W'(X_INIT);
      y        <= DATA_W'(Y_INIT);
      vx       <= '0;
      vy       <= '0;
      dx       <= DIR_POS;
      dy       <= DIR_POS;
      col_ack  <= 1'b0;
      wall_hit <= 1'b0;
      cool     <= '0;
      fcnt     <= '0;
    end else begin
      col_ack  <= 1'b0;
      wall_hit <= 1'b0;

      if (step_en) begin
        x        <= ax_pos;
        y        <= ay_pos;
        dx       <= ax_d;
        dy       <= ay_d;
        wall_hit <= ax_hit || ay_hit;
        vx       <= vx_fr;
        vy       <= vy_fr;
        fcnt     <= fr_wrap ? '0 : fcnt + FC_W'(1);
      end

      if (capture) begin
        vx      <= sat_speed(col_vx);
        vy      <= sat_speed(col_vy);
        dx      <= dir_decode(col_dx, dx);
        dy      <= dir_decode(col_dy, dy);
        cool    <= CD_W'(COOLDOWN);
        col_ack <= 1'b1;
        state   <= ST_HOLD;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (shot_valid) begin
              vx <= shot_vxs;
              vy <= shot_vys;
              dx <= dir_decode(shot_dx, dx);
              dy <= dir_decode(shot_dy, dy);
              if ((shot_vxs | shot_vys) != '0) state <= ST_MOVE;
            end
          end
          ST_MOVE: begin
            if (step_en && vx_fr == '0 && vy_fr == '0) state <= ST_IDLE;
          end
          ST_HOLD: begin
            if (step_en) begin
              cool <= cool - CD_W'(1);
              if (cool <= CD_W'(1))
                state <= (vx_fr == '0 && vy_fr == '0) ? ST_IDLE : ST_MOVE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: expectations are queued as stimulus is
// applied and compared once the DUT has registered its response.
module tb_ball_motion;

  logic clk = 1'b0;
  logic rst, frame_tick, shot_valid, col_valid;
  logic [9:0] shot_vx, shot_vy, shot_dx, shot_dy;
  logic [9:0] col_vx, col_vy, col_dx, col_dy;
  logic col_ack, moving, wall_hit;
  logic [9:0] x, y, vx, vy;
  logic signed [9:0] dx, dy;

  logic rst_f, tick_f, shot_valid_f, col_valid_f;
  logic f_col_ack, f_moving, f_wall_hit;
  logic [9:0] f_x, f_y, f_vx, f_vy;
  logic signed [9:0] f_dx, f_dy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ball_motion dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .shot_valid(shot_valid), .shot_vx(shot_vx), .shot_vy(shot_vy),
    .shot_dx(shot_dx), .shot_dy(shot_dy),
    .col_valid(col_valid), .col_vx(col_vx), .col_vy(col_vy),
    .col_dx(col_dx), .col_dy(col_dy), .col_ack(col_ack),
    .x(x), .y(y), .vx(vx), .vy(vy), .dx(dx), .dy(dy),
    .moving(moving), .wall_hit(wall_hit)
  );

  ball_motion #(.FRICTION_DIV(4)) dutf (
    .clk(clk), .rst(rst_f), .frame_tick(tick_f),
    .shot_valid(shot_valid_f), .shot_vx(shot_vx), .shot_vy(shot_vy),
    .shot_dx(shot_dx), .shot_dy(shot_dy),
    .col_valid(col_valid_f), .col_vx(col_vx), .col_vy(col_vy),
    .col_dx(col_dx), .col_dy(col_dy), .col_ack(f_col_ack),
    .x(f_x), .y(f_y), .vx(f_vx), .vy(f_vy), .dx(f_dx), .dy(f_dy),
    .moving(f_moving), .wall_hit(f_wall_hit)
  );

  localparam int S_X = 0, S_Y = 1, S_VX = 2, S_VY = 3, S_DX = 4, S_DY = 5;
  localparam int S_MOV = 6, S_WALL = 7, S_ACK = 8;
  localparam int S_FX = 10, S_FVX = 11, S_FMOV = 12;

  function automatic int observe(int sel);
    case (sel)
      S_X:    return int'(x);
      S_Y:    return int'(y);
      S_VX:   return int'(vx);
      S_VY:   return int'(vy);
      S_DX:   return int'(dx);
      S_DY:   return int'(dy);
      S_MOV:  return int'(moving);
      S_WALL: return int'(wall_hit);
      S_ACK:  return int'(col_ack);
      S_FX:   return int'(f_x);
      S_FVX:  return int'(f_vx);
      S_FMOV: return int'(f_moving);
      default: return -999;
    endcase
  endfunction

  function automatic void want(string tag, int sel, int val);
    sb.push_back('{tag, sel, val});
  endfunction

  task automatic drain();
    exp_t e;
    int obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
    end
  endtask

  task automatic fticks(int n);
    for (int i = 0; i < n; i++) begin
      tick_f = 1'b1;
      cyc();
      tick_f = 1'b0;
    end
  endtask

  task automatic shot(input int svx, input int svy, input logic [9:0] sdx, input logic [9:0] sdy);
    shot_vx = 10'(svx); shot_vy = 10'(svy); shot_dx = sdx; shot_dy = sdy;
    shot_valid = 1'b1;
    cyc();
    shot_valid = 1'b0;
  endtask

  task automatic reset_main();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; shot_valid = 1'b0; col_valid = 1'b0;
    shot_vx = '0; shot_vy = '0; shot_dx = '0; shot_dy = '0;
    col_vx = '0; col_vy = '0; col_dx = '0; col_dy = '0;
    rst_f = 1'b1; tick_f = 1'b0; shot_valid_f = 1'b0; col_valid_f = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    want("rst_x", S_X, 100); want("rst_y", S_Y, 240);
    want("rst_vx", S_VX, 0); want("rst_vy", S_VY, 0);
    want("rst_dx", S_DX, 1); want("rst_dy", S_DY, 1);
    want("rst_moving", S_MOV, 0); want("rst_ack", S_ACK, 0); want("rst_wall", S_WALL, 0);
    drain();

    // Shot then one frame
    shot(3, 0, 10'd1, 10'd0);
    want("shot_moving", S_MOV, 1); want("shot_vx", S_VX, 3);
    drain();
    frames(1);
    want("t1_x", S_X, 103); want("t1_y", S_Y, 240); want("t1_moving", S_MOV, 1);
    drain();

    // Collision capture in MOVE, held col_valid acked once
    col_vx = 10'd4; col_vy = 10'd2; col_dx = 10'h3FF; col_dy = 10'd1;
    col_valid = 1'b1;
    cyc();
    want("cap_ack", S_ACK, 1); want("cap_vx", S_VX, 4); want("cap_vy", S_VY, 2);
    want("cap_dx", S_DX, -1); want("cap_dy", S_DY, 1); want("cap_x", S_X, 103);
    drain();
    cyc();
    want("cap_ack_once", S_ACK, 0); want("cap_vx_hold", S_VX, 4);
    drain();
    col_valid = 1'b0;
    frames(3);
    col_vx = 10'd9; col_vy = 10'd9; col_dx = 10'd1; col_dy = 10'd0;
    col_valid = 1'b1;
    cyc();
    col_valid = 1'b0;
    want("cd_no_ack", S_ACK, 0); want("cd_no_vx", S_VX, 4); want("cd_no_dx", S_DX, -1);
    want("hold_x", S_X, 91); want("hold_y", S_Y, 246);
    drain();
    frames(6);
    want("post_cd_x", S_X, 67); want("post_cd_y", S_Y, 258); want("post_cd_moving", S_MOV, 1);
    drain();
    col_vx = 10'd1; col_vy = 10'd1; col_dx = 10'd0; col_dy = 10'd0;
    col_valid = 1'b1;
    cyc();
    col_valid = 1'b0;
    want("recap_ack", S_ACK, 1); want("recap_vx", S_VX, 1);
    drain();

    // Reset mid-HOLD with a frame tick pending
    frames(2);
    rst = 1'b1; frame_tick = 1'b1;
    cyc();
    rst = 1'b0; frame_tick = 1'b0;
    want("hrst_x", S_X, 100); want("hrst_y", S_Y, 240);
    want("hrst_vx", S_VX, 0); want("hrst_vy", S_VY, 0);
    want("hrst_dx", S_DX, 1); want("hrst_dy", S_DY, 1);
    want("hrst_moving", S_MOV, 0); want("hrst_ack", S_ACK, 0); want("hrst_wall", S_WALL, 0);
    drain();

    // Cushion reflection at x=606 with vx=5
    shot(11, 0, 10'd1, 10'd0);
    frames(46);
    want("pre_wall_x", S_X, 606); want("pre_wall_vx", S_VX, 11); want("pre_wall_wall", S_WALL, 0);
    drain();
    col_vx = 10'd5; col_vy = 10'd0; col_dx = 10'd0; col_dy = 10'd0;
    col_valid = 1'b1;
    cyc();
    col_valid = 1'b0;
    want("w_load_vx", S_VX, 5); want("w_load_dx", S_DX, 1);
    drain();
    frames(1);
    want("wall_x", S_X, 608); want("wall_dx", S_DX, -1); want("wall_pulse", S_WALL, 1);
    want("wall_y", S_Y, 240);
    drain();
    cyc();
    want("wall_pulse_end", S_WALL, 0);
    drain();

    // Capture coinciding with frame tick, speed saturation
    frames(8);
    want("pre_cap_x", S_X, 568);
    drain();
    col_vx = 10'd40; col_vy = 10'd3; col_dx = 10'd7; col_dy = 10'h200;
    col_valid = 1'b1; frame_tick = 1'b1;
    cyc();
    col_valid = 1'b0; frame_tick = 1'b0;
    want("ct_x", S_X, 568); want("ct_y", S_Y, 240);
    want("ct_vx_sat", S_VX, 15); want("ct_vy", S_VY, 3);
    want("ct_dx", S_DX, 1); want("ct_dy", S_DY, -1); want("ct_ack", S_ACK, 1);
    drain();

    // Friction on the FRICTION_DIV=4 instance
    rst_f = 1'b0;
    shot_vx = 10'd2; shot_vy = 10'd0; shot_dx = 10'd1; shot_dy = 10'd0;
    shot_valid_f = 1'b1;
    cyc();
    shot_valid_f = 1'b0;
    want("fr_vx0", S_FVX, 2); want("fr_mov0", S_FMOV, 1);
    drain();
    fticks(3);
    want("fr_vx3", S_FVX, 2); want("fr_x3", S_FX, 106);
    drain();
    fticks(1);
    want("fr_vx4", S_FVX, 1); want("fr_x4", S_FX, 108);
    drain();
    fticks(3);
    want("fr_vx7", S_FVX, 1); want("fr_mov7", S_FMOV, 1);
    drain();
    fticks(1);
    want("fr_vx8", S_FVX, 0); want("fr_mov8", S_FMOV, 0); want("fr_x8", S_FX, 112);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
